// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the two-digit seven-segment path: segment
//   patterns (bit0=a .. bit6=g, active-high), digit strobe encodings,
//   the reader FSM state type and the pattern-to-BCD decode used on both
//   the driver and reader sides so the two tables cannot drift apart.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  typedef enum logic [1:0] {
    S_HUNT     = 2'd0,
    S_GOT_ONES = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] bcd;
  } seg_dec_t;

  // Inverse of the driver table. A blank pattern is only meaningful as a
  // suppressed leading zero, so the caller says whether it is acceptable.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg,
                                          input logic       blank_ok);
    seg_dec_t r;
    r.ok  = 1'b1;
    r.bcd = 4'd0;
    case (seg)
      SEG_0:     r.bcd = 4'd0;
      SEG_1:     r.bcd = 4'd1;
      SEG_2:     r.bcd = 4'd2;
      SEG_3:     r.bcd = 4'd3;
      SEG_4:     r.bcd = 4'd4;
      SEG_5:     r.bcd = 4'd5;
      SEG_6:     r.bcd = 4'd6;
      SEG_7:     r.bcd = 4'd7;
      SEG_8:     r.bcd = 4'd8;
      SEG_9:     r.bcd = 4'd9;
      SEG_BLANK: r.ok  = blank_ok;
      default:   r.ok  = 1'b0;
    endcase
    return r;
  endfunction

  // tens*10 + ones as (tens<<3) + (tens<<1) + ones; max 99 fits in 8 bits.
  function automatic logic [7:0] bcd_to_bin(input logic [3:0] t,
                                            input logic [3:0] o);
    return {1'b0, t, 3'b000} + {3'b000, t, 1'b0} + {4'b0000, o};
  endfunction

endpackage

// File: rtl/seven_seg_scan_reader_if.sv
// seven_seg_scan_reader_if
//   Bundle between a multiplexed segment bus and the reader's decoded
//   result. master = whatever drives the segment bus and consumes the
//   result; slave = the reader itself.
//   seg_in/dig_sel : segment pattern and digit strobe
//   ones/tens/num  : last committed value
//   valid/update/err/err_cnt : status
interface seven_seg_scan_reader_if;
  logic [6:0] seg_in;
  logic [1:0] dig_sel;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [7:0] num;
  logic       valid;
  logic       update;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output seg_in, dig_sel,
    input  ones, tens, num, valid, update, err, err_cnt
  );

  modport slave (
    input  seg_in, dig_sel,
    output ones, tens, num, valid, update, err, err_cnt
  );
endinterface

// File: rtl/seg_stabilizer.sv
// seg_stabilizer
//   Debounces the multiplexed bus: {dig_sel, seg_in} must be seen unchanged
//   on STABLE_CYCLES consecutive cycles with a one-hot strobe before a
//   single accept pulse is produced. The accepted sample is presented on
//   dig_hold/seg_hold in the same cycle as the pulse.
//   clk, rst         : clock, synchronous active-high reset
//   dig_sel, seg_in  : raw bus
//   accept           : one-cycle pulse per stable value
//   dig_hold/seg_hold: the value being accepted
module seg_stabilizer
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dig_sel,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [1:0] dig_hold,
  output logic [6:0] seg_hold
);

  localparam logic [7:0] CNT_TOP = 8'(STABLE_CYCLES - 1);

  logic [8:0] smp_q, smp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       acc_q, acc_d;
  logic       one_hot;
  logic       same;

  always_comb begin
    smp_d   = {dig_sel, seg_in};
    one_hot = (dig_sel == DIG_ONES) || (dig_sel == DIG_TENS);
    same    = (smp_d == smp_q);
    cnt_d   = 8'd0;
    acc_d   = 1'b0;
    if (same && one_hot) begin
      // Park at the top so a long-held value produces exactly one pulse.
      cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 8'd1;
      acc_d = (cnt_q == CNT_TOP - 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      smp_q <= smp_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign accept   = acc_q;
  assign dig_hold = smp_q[8:7];
  assign seg_hold = smp_q[6:0];

endmodule

// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader
//   Reads back a two-digit multiplexed seven-segment bus. Stable digits are
//   decoded to BCD; a frame is a ones digit followed by a tens digit, and
//   a complete legal frame updates ones/tens/num. valid drops if no legal
//   frame arrives for TIMEOUT_CYCLES cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seven_seg_scan_reader_if (segment bus in,
//              ones/tens/num/valid/update/err/err_cnt out)
module seven_seg_scan_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  seven_seg_scan_reader_if.slave bus
);

  localparam logic [15:0] TO_TOP = 16'(TIMEOUT_CYCLES);

  logic       accept;
  logic [1:0] dig_hold;
  logic [6:0] seg_hold;

  seg_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk      (clk),
    .rst      (rst),
    .dig_sel  (bus.dig_sel),
    .seg_in   (bus.seg_in),
    .accept   (accept),
    .dig_hold (dig_hold),
    .seg_hold (seg_hold)
  );

  state_t      state_q, state_d;
  logic [3:0]  ones_tmp_q, ones_tmp_d;
  logic        ones_ok_q, ones_ok_d;
  logic [3:0]  tens_tmp_q, tens_tmp_d;
  logic        tens_ok_q, tens_ok_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [7:0]  num_q, num_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  seg_dec_t    dec_ones;
  seg_dec_t    dec_tens;
  logic [7:0]  new_num;
  logic        commit_ok;

  assign dec_ones = seg_decode(seg_hold, 1'b0);
  assign dec_tens = seg_decode(seg_hold, 1'b1);

  always_comb begin
    state_d    = state_q;
    ones_tmp_d = ones_tmp_q;
    ones_ok_d  = ones_ok_q;
    tens_tmp_d = tens_tmp_q;
    tens_ok_d  = tens_ok_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    num_d      = num_q;
    valid_d    = valid_q;
    update_d   = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    to_cnt_d   = to_cnt_q;
    new_num    = bcd_to_bin(tens_tmp_q, ones_tmp_q);
    commit_ok  = 1'b0;

    case (state_q)
      S_HUNT: begin
        // A frame always starts with ones; a stray tens digit is dropped.
        if (accept && dig_hold == DIG_ONES) begin
          ones_tmp_d = dec_ones.bcd;
          ones_ok_d  = dec_ones.ok;
          state_d    = S_GOT_ONES;
        end
      end
      S_GOT_ONES: begin
        if (accept && dig_hold == DIG_ONES) begin
          ones_tmp_d = dec_ones.bcd;
          ones_ok_d  = dec_ones.ok;
        end else if (accept && dig_hold == DIG_TENS) begin
          tens_tmp_d = dec_tens.bcd;
          tens_ok_d  = dec_tens.ok;
          state_d    = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_HUNT;
        if (ones_ok_q && tens_ok_q) begin
          commit_ok = 1'b1;
          ones_d    = ones_tmp_q;
          tens_d    = tens_tmp_q;
          num_d     = new_num;
          valid_d   = 1'b1;
          update_d  = (new_num != num_q) || !valid_q;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A legal commit restarts the timeout and overrides a coincident expiry.
    if (commit_ok) begin
      to_cnt_d = 16'd0;
    end else begin
      to_cnt_d = (to_cnt_q == TO_TOP) ? to_cnt_q : to_cnt_q + 16'd1;
      if (to_cnt_d == TO_TOP) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HUNT;
      ones_tmp_q <= '0;
      ones_ok_q  <= 1'b0;
      tens_tmp_q <= '0;
      tens_ok_q  <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      num_q      <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ones_tmp_q <= ones_tmp_d;
      ones_ok_q  <= ones_ok_d;
      tens_tmp_q <= tens_tmp_d;
      tens_ok_q  <= tens_ok_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.ones    = ones_q;
  assign bus.tens    = tens_q;
  assign bus.num     = num_q;
  assign bus.valid   = valid_q;
  assign bus.update  = update_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// tb_seven_seg_scan_reader
//   Directed bench for seven_seg_scan_reader with STABLE_CYCLES=4 and
//   TIMEOUT_CYCLES=1000. Inputs change 1 ns after a rising edge and
//   outputs are sampled at the same point.
module tb_seven_seg_scan_reader;
  import seven_seg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seven_seg_scan_reader_if bus ();

  seven_seg_scan_reader #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Ones for 4 cycles, tens for 4 cycles, then idle. Returns just after the
  // edge that registers the commit (2 cycles after the tens accept pulse).
  task automatic run_frame(input logic [6:0] o, input logic [6:0] t, input bit early);
    bus.dig_sel = DIG_ONES;
    bus.seg_in  = o;
    repeat (4) tick();
    bus.dig_sel = DIG_TENS;
    bus.seg_in  = t;
    repeat (4) tick();
    bus.dig_sel = 2'b00;
    bus.seg_in  = 7'h00;
    tick();
    if (early) chk("upd_early", {15'd0, bus.update}, 16'd0);
    tick();
    $display("frame ones_seg=%02h tens_seg=%02h -> num=%0d valid=%0b update=%0b err=%0b err_cnt=%0d",
             o, t, bus.num, bus.valid, bus.update, bus.err, bus.err_cnt);
  endtask

  initial begin
    rst         = 1'b1;
    bus.dig_sel = 2'b00;
    bus.seg_in  = 7'h00;
    repeat (2) tick();
    chk("rst_ones",    {12'd0, bus.ones},    16'd0);
    chk("rst_tens",    {12'd0, bus.tens},    16'd0);
    chk("rst_num",     {8'd0,  bus.num},     16'd0);
    chk("rst_valid",   {15'd0, bus.valid},   16'd0);
    chk("rst_update",  {15'd0, bus.update},  16'd0);
    chk("rst_err",     {15'd0, bus.err},     16'd0);
    chk("rst_err_cnt", {8'd0,  bus.err_cnt}, 16'd0);

    // Reset in the middle of a frame: ones already taken, tens in progress.
    rst         = 1'b0;
    bus.dig_sel = DIG_ONES;
    bus.seg_in  = SEG_5;
    repeat (4) tick();
    bus.dig_sel = DIG_TENS;
    bus.seg_in  = SEG_3;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst_num",   {8'd0,  bus.num},   16'd0);
    chk("midrst_valid", {15'd0, bus.valid}, 16'd0);
    rst = 1'b0;
    // Tens alone must not complete the discarded frame.
    repeat (6) tick();
    bus.dig_sel = 2'b00;
    bus.seg_in  = 7'h00;
    repeat (3) tick();
    chk("orphan_tens_num",   {8'd0,  bus.num},   16'd0);
    chk("orphan_tens_valid", {15'd0, bus.valid}, 16'd0);
    $display("mid-frame reset done");

    // 35
    run_frame(SEG_5, SEG_3, 1'b1);
    chk("f35_ones",   {12'd0, bus.ones},   16'd5);
    chk("f35_tens",   {12'd0, bus.tens},   16'd3);
    chk("f35_num",    {8'd0,  bus.num},    16'd35);
    chk("f35_valid",  {15'd0, bus.valid},  16'd1);
    chk("f35_update", {15'd0, bus.update}, 16'd1);
    chk("f35_err",    {15'd0, bus.err},    16'd0);
    tick();
    chk("f35_upd_drop", {15'd0, bus.update}, 16'd0);

    // Same value again: no update.
    run_frame(SEG_5, SEG_3, 1'b0);
    chk("rep35_update", {15'd0, bus.update}, 16'd0);
    chk("rep35_valid",  {15'd0, bus.valid},  16'd1);
    chk("rep35_num",    {8'd0,  bus.num},    16'd35);

    // 18
    run_frame(SEG_8, SEG_1, 1'b1);
    chk("f18_ones",   {12'd0, bus.ones},   16'd8);
    chk("f18_tens",   {12'd0, bus.tens},   16'd1);
    chk("f18_num",    {8'd0,  bus.num},    16'd18);
    chk("f18_update", {15'd0, bus.update}, 16'd1);

    // Ones toggling every 3 cycles never settles; then idle until timeout.
    for (int r = 0; r < 10; r++) begin
      bus.dig_sel = DIG_ONES;
      bus.seg_in  = SEG_1;
      repeat (3) tick();
      bus.seg_in  = SEG_2;
      repeat (3) tick();
    end
    bus.dig_sel = 2'b00;
    bus.seg_in  = 7'h00;
    repeat (939) tick();
    chk("to_before_valid", {15'd0, bus.valid}, 16'd1);
    chk("toggle_num",      {8'd0,  bus.num},   16'd18);
    tick();
    chk("to_valid",  {15'd0, bus.valid}, 16'd0);
    chk("to_num",    {8'd0,  bus.num},   16'd18);
    chk("to_ones",   {12'd0, bus.ones},  16'd8);
    $display("timeout reached");

    // Illegal ones pattern.
    run_frame(7'h12, SEG_1, 1'b0);
    chk("ill_err",     {15'd0, bus.err},     16'd1);
    chk("ill_update",  {15'd0, bus.update},  16'd0);
    chk("ill_err_cnt", {8'd0,  bus.err_cnt}, 16'd1);
    chk("ill_num",     {8'd0,  bus.num},     16'd18);
    chk("ill_valid",   {15'd0, bus.valid},   16'd0);
    tick();
    chk("ill_err_drop", {15'd0, bus.err}, 16'd0);

    // Blank tens = leading zero.
    run_frame(SEG_7, SEG_BLANK, 1'b0);
    chk("blank_ones",   {12'd0, bus.ones},   16'd7);
    chk("blank_tens",   {12'd0, bus.tens},   16'd0);
    chk("blank_num",    {8'd0,  bus.num},    16'd7);
    chk("blank_valid",  {15'd0, bus.valid},  16'd1);
    chk("blank_update", {15'd0, bus.update}, 16'd1);

    // Next commit lands exactly 1000 cycles after the previous one.
    bus.dig_sel = 2'b00;
    bus.seg_in  = 7'h00;
    repeat (990) tick();
    run_frame(SEG_7, SEG_BLANK, 1'b0);
    chk("edge_valid",  {15'd0, bus.valid},  16'd1);
    chk("edge_update", {15'd0, bus.update}, 16'd0);
    chk("edge_num",    {8'd0,  bus.num},    16'd7);

    // Blank ones is illegal; drive err_cnt into saturation.
    for (int i = 0; i < 254; i++) run_frame(SEG_BLANK, SEG_0, 1'b0);
    chk("sat_reach", {8'd0, bus.err_cnt}, 16'd255);
    for (int i = 0; i < 2; i++) run_frame(SEG_BLANK, SEG_0, 1'b0);
    chk("sat_hold",  {8'd0, bus.err_cnt}, 16'd255);
    chk("sat_err",   {15'd0, bus.err},    16'd1);
    chk("sat_num",   {8'd0, bus.num},     16'd7);
    chk("sat_valid", {15'd0, bus.valid},  16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
